event_trigger_generator: RTL and testbench



---
 rtl/event_trigger_generator.sv | 190 +++++++++++++++++++
 tb/tb_event_trigger_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/event_trigger_generator.sv
// event_trigger_generator: matches the decoded EVR event stream against a
// programmable code and issues a registered one-cycle triggerStrobe, with
// prescaling, a holdoff window, continuous/single-shot arming and status counters.
// Latency: triggerStrobe is high the cycle after the accepted match. No backpressure.
// Optional feature macro: EVENT_TRIGGER_MISSED_COUNT_EN (missedCount register).
module event_trigger_generator #(
  parameter int EVENT_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int HOLDOFF_WIDTH  = 20,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   evrClk,
  input  logic                   evrRst_n,
  input  logic                   csrStrobe,
  input  logic [31:0]            csrData,
  input  logic [EVENT_WIDTH-1:0] eventCode,
  input  logic                   eventValid,
  output logic                   triggerStrobe,
  output logic                   armed,
  output logic [COUNT_WIDTH-1:0] triggerCount,
  output logic [COUNT_WIDTH-1:0] missedCount
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ARMED    = 2'd1,
    S_HOLDOFF  = 2'd2
  } state_t;

  localparam logic [1:0] OP_CTRL     = 2'd0;
  localparam logic [1:0] OP_MATCH    = 2'd1;
  localparam logic [1:0] OP_PRESCALE = 2'd2;
  localparam logic [1:0] OP_HOLDOFF  = 2'd3;

  // configuration registers
  logic [1:0]                mode_q, mode_d;
  logic [EVENT_WIDTH-1:0]    match_code_q, match_code_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [HOLDOFF_WIDTH-1:0]  holdoff_q, holdoff_d;

  // FSM and its working counters
  state_t                    state_q;
  logic [PRESCALE_WIDTH-1:0] prescale_cnt_q;
  logic [HOLDOFF_WIDTH-1:0]  holdoff_cnt_q;
  logic                      strobe_q;

  // status
  logic [COUNT_WIDTH-1:0]    trig_cnt_q, trig_cnt_d;

  logic [1:0] csr_op;
  logic [1:0] new_mode;
  logic       ctrl_wr;
  logic       new_run;
  logic       cnt_clr;
  logic       match;
  logic       fire;
  logic       csr_unused;

  assign csr_op   = csrData[31:30];
  assign new_mode = csrData[1:0];
  assign ctrl_wr  = csrStrobe && (csr_op == OP_CTRL);
  assign new_run  = (new_mode == 2'd1) || (new_mode == 2'd2);
  assign cnt_clr  = ctrl_wr && csrData[2];
  // Only some csrData bits carry fields; the rest are deliberately ignored.
  assign csr_unused = ^csrData;

  // Any CSR write in the same cycle discards the event so config and matching never race.
  assign match = eventValid && !csrStrobe && (match_code_q != '0) &&
                 (eventCode == match_code_q);
  assign fire  = (state_q == S_ARMED) && match && (prescale_cnt_q == '0);

  // Next-state for configuration registers and the trigger counter.
  always_comb begin
    mode_d       = mode_q;
    match_code_d = match_code_q;
    prescale_d   = prescale_q;
    holdoff_d    = holdoff_q;
    if (csrStrobe) begin
      case (csr_op)
        OP_CTRL:     mode_d       = new_mode;
        OP_MATCH:    match_code_d = csrData[EVENT_WIDTH-1:0];
        OP_PRESCALE: prescale_d   = csrData[PRESCALE_WIDTH-1:0];
        OP_HOLDOFF:  holdoff_d    = csrData[HOLDOFF_WIDTH-1:0];
        default:     ;
      endcase
    end
    trig_cnt_d = trig_cnt_q;
    if (cnt_clr) begin
      trig_cnt_d = '0;
    end else if (fire && (trig_cnt_q != '1)) begin
      trig_cnt_d = trig_cnt_q + 1'b1;
    end
  end

  // Configuration and trigger counter registers.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      mode_q       <= 2'd0;
      match_code_q <= '0;
      prescale_q   <= '0;
      holdoff_q    <= '0;
      trig_cnt_q   <= '0;
    end else begin
      mode_q       <= mode_d;
      match_code_q <= match_code_d;
      prescale_q   <= prescale_d;
      holdoff_q    <= holdoff_d;
      trig_cnt_q   <= trig_cnt_d;
    end
  end

  // Arming FSM with prescale/holdoff counters and the registered strobe.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      state_q        <= S_DISABLED;
      prescale_cnt_q <= '0;
      holdoff_cnt_q  <= '0;
      strobe_q       <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (ctrl_wr) begin
        // Control writes restart prescaling and abort any holdoff in progress.
        prescale_cnt_q <= prescale_q;
        state_q        <= new_run ? S_ARMED : S_DISABLED;
      end else begin
        case (state_q)
          S_ARMED: begin
            if (match) begin
              if (prescale_cnt_q == '0) begin
                strobe_q       <= 1'b1;
                prescale_cnt_q <= prescale_q;
                if (mode_q == 2'd2) begin
                  state_q <= S_DISABLED;
                end else if (holdoff_q != '0) begin
                  state_q       <= S_HOLDOFF;
                  holdoff_cnt_q <= holdoff_q - 1'b1;
                end
              end else begin
                prescale_cnt_q <= prescale_cnt_q - 1'b1;
              end
            end
          end
          S_HOLDOFF: begin
            if (holdoff_cnt_q == '0) begin
              state_q <= S_ARMED;
            end else begin
              holdoff_cnt_q <= holdoff_cnt_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef EVENT_TRIGGER_MISSED_COUNT_EN
  logic [COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic                   miss;

  assign miss = (state_q == S_HOLDOFF) && match;

  // Saturating count of matches swallowed by the holdoff window; clear wins.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      miss_cnt_d = '0;
    end else if (miss && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  // Missed-match counter register.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign missedCount = miss_cnt_q;
`else
  assign missedCount = '0;
`endif

  assign triggerStrobe = strobe_q;
  assign armed         = (state_q == S_ARMED) || (state_q == S_HOLDOFF);
  assign triggerCount  = trig_cnt_q;

endmodule

// File: tb/tb_event_trigger_generator.sv
// Directed bench for event_trigger_generator: inputs change 1ns after the
// rising edge, outputs are sampled at the same point, so each tick() moves
// one cycle and shows the registered result of the previous cycle's inputs.
module tb_event_trigger_generator;

  logic        evrClk;
  logic        evrRst_n;
  logic        csrStrobe;
  logic [31:0] csrData;
  logic [7:0]  eventCode;
  logic        eventValid;
  logic        triggerStrobe;
  logic        armed;
  logic [31:0] triggerCount;
  logic [31:0] missedCount;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_miss;

  event_trigger_generator dut (
    .evrClk        (evrClk),
    .evrRst_n      (evrRst_n),
    .csrStrobe     (csrStrobe),
    .csrData       (csrData),
    .eventCode     (eventCode),
    .eventValid    (eventValid),
    .triggerStrobe (triggerStrobe),
    .armed         (armed),
    .triggerCount  (triggerCount),
    .missedCount   (missedCount)
  );

  initial evrClk = 1'b0;
  always #5 evrClk = ~evrClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic csr(input logic [1:0] op, input logic [29:0] val);
    csrStrobe = 1'b1;
    csrData   = {op, val};
    tick();
    csrStrobe = 1'b0;
    csrData   = '0;
  endtask

  task automatic ev(input logic [7:0] code);
    eventValid = 1'b1;
    eventCode  = code;
    tick();
    eventValid = 1'b0;
    eventCode  = '0;
  endtask

  initial begin
`ifdef EVENT_TRIGGER_MISSED_COUNT_EN
    exp_miss = 32'd1;
`else
    exp_miss = 32'd0;
`endif
    evrRst_n   = 1'b0;
    csrStrobe  = 1'b0;
    csrData    = '0;
    eventCode  = '0;
    eventValid = 1'b0;
    idle(3);
    check("rst_strobe", {31'd0, triggerStrobe}, 32'd0);
    check("rst_armed",  {31'd0, armed}, 32'd0);
    check("rst_trig",   triggerCount, 32'd0);
    check("rst_miss",   missedCount, 32'd0);
    evrRst_n = 1'b1;
    idle(2);

    // Disabled after reset: matches ignored
    csr(2'd1, 30'h2A);
    ev(8'h2A);
    check("dis_strobe", {31'd0, triggerStrobe}, 32'd0);
    check("dis_trig",   triggerCount, 32'd0);

    // 1: prescale 0, holdoff 0, back-to-back strobes
    csr(2'd2, 30'd0);
    csr(2'd3, 30'd0);
    csr(2'd0, 30'h5);
    check("t1_armed", {31'd0, armed}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      ev(8'h2A);
      check($sformatf("t1_strobe%0d", i), {31'd0, triggerStrobe}, 32'd1);
      check($sformatf("t1_cnt%0d", i), triggerCount, i);
    end
    ev(8'h2B);
    check("t1_nomatch", {31'd0, triggerStrobe}, 32'd0);
    check("t1_trig", triggerCount, 32'd3);

    // 2: prescale 2 -> fire on every third match
    csr(2'd2, 30'd2);
    csr(2'd0, 30'h5);
    check("t2_clr", triggerCount, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      ev(8'h2A);
      check($sformatf("t2_strobe%0d", i), {31'd0, triggerStrobe}, (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    check("t2_trig", triggerCount, 32'd2);

    // 3: holdoff 5; matches at cycles 0,3,5 (strobe at 1), then 6 accepted
    csr(2'd2, 30'd0);
    csr(2'd3, 30'd5);
    csr(2'd0, 30'h5);
    ev(8'h2A);                         // cycle 0
    check("t3_strobe0", {31'd0, triggerStrobe}, 32'd1);
    check("t3_armed_ho", {31'd0, armed}, 32'd1);
    idle(2);                           // cycles 1,2
    ev(8'h2A);                         // cycle 3
    check("t3_strobe3", {31'd0, triggerStrobe}, 32'd0);
    check("t3_miss3", missedCount, exp_miss);
    tick();                            // cycle 4
    ev(8'h2A);                         // cycle 5
    check("t3_strobe5", {31'd0, triggerStrobe}, 32'd0);
    check("t3_miss5", missedCount, exp_miss * 2);
    ev(8'h2A);                         // cycle 6
    check("t3_strobe6", {31'd0, triggerStrobe}, 32'd1);
    check("t3_trig", triggerCount, 32'd2);

    // 4: single-shot
    csr(2'd3, 30'd0);
    csr(2'd0, 30'h6);
    check("t4_armed", {31'd0, armed}, 32'd1);
    check("t4_missclr", missedCount, 32'd0);
    ev(8'h2A);
    check("t4_strobe1", {31'd0, triggerStrobe}, 32'd1);
    check("t4_disarm", {31'd0, armed}, 32'd0);
    idle(19);
    ev(8'h2A);
    check("t4_strobe2", {31'd0, triggerStrobe}, 32'd0);
    check("t4_trig", triggerCount, 32'd1);
    check("t4_armed_end", {31'd0, armed}, 32'd0);

    // 5: CSR write coincident with a match discards the match
    csr(2'd0, 30'h5);
    csrStrobe  = 1'b1;
    csrData    = 32'h0000_0001;
    eventValid = 1'b1;
    eventCode  = 8'h2A;
    tick();
    csrStrobe  = 1'b0;
    csrData    = '0;
    eventValid = 1'b0;
    check("t5_strobe", {31'd0, triggerStrobe}, 32'd0);
    check("t5_trig", triggerCount, 32'd0);
    ev(8'h2A);
    check("t5_next", {31'd0, triggerStrobe}, 32'd1);
    check("t5_trig2", triggerCount, 32'd1);
    csr(2'd0, 30'h3);
    check("t5_mode3", {31'd0, armed}, 32'd0);

    // 6: match code 0 never matches; async reset during holdoff
    csr(2'd1, 30'h0);
    csr(2'd0, 30'h1);
    ev(8'h00);
    check("t6_code0", {31'd0, triggerStrobe}, 32'd0);
    check("t6_code0_cnt", triggerCount, 32'd1);
    csr(2'd1, 30'h2A);
    csr(2'd3, 30'd10);
    csr(2'd0, 30'h1);
    ev(8'h2A);
    check("t6_strobe", {31'd0, triggerStrobe}, 32'd1);
    ev(8'h2A);
    check("t6_miss", missedCount, exp_miss);
    eventValid = 1'b1;
    eventCode  = 8'h2A;
    #2;
    evrRst_n = 1'b0;
    #1;
    check("t6_rst_armed", {31'd0, armed}, 32'd0);
    check("t6_rst_trig", triggerCount, 32'd0);
    check("t6_rst_miss", missedCount, 32'd0);
    check("t6_rst_strobe", {31'd0, triggerStrobe}, 32'd0);
    eventValid = 1'b0;
    tick();
    evrRst_n = 1'b1;
    tick();
    // config returned to reset: arming with matchCode 0 yields nothing
    csr(2'd0, 30'h1);
    ev(8'h2A);
    check("t6_post_code", {31'd0, triggerStrobe}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
